// File: rtl/skyhop_defs.sv
// ============================================================================
// Module : skyhop_defs
// Brief  : Shared constants and state encoding for the layer stack logic.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package skyhop_defs;

   localparam int ROW_W = 7;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_READY  = 2'd2,
      S_SCROLL = 2'd3
   } state_t;

   localparam logic [ROW_W-1:0] FLOOR_MAP    = '1;
   localparam logic [ROW_W-1:0] FALLBACK_MAP = 7'b0001000;
   // x^8 + x^6 + x^5 + x^4 + 1, taps on bits 7,5,4,3 of a left-shifting register
   localparam logic [7:0]       LFSR_TAPS    = 8'b1011_1000;

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
// ============================================================================
// Module : lfsr8
// Brief  : 8-bit Fibonacci LFSR, free running, zero seed replaced by 8'h01.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lfsr8
   import skyhop_defs::*;
(
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [7:0] seed,
   output logic [7:0] out
);

   logic [7:0] r_lfsr;
   logic [7:0] w_seed;

   assign w_seed = (seed == 8'h00) ? 8'h01 : seed;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_lfsr <= w_seed;
      end else begin
         r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
      end
   end

   assign out = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/layer_scheduler.sv
// ============================================================================
// Module : layer_scheduler
// Brief  : Ring buffer of generated platform rows with fill/scroll control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module layer_scheduler
   import skyhop_defs::*;
#(
   parameter int         LAYERS = 8,
   parameter int         ROW_W  = skyhop_defs::ROW_W,
   parameter logic [7:0] SEED   = 8'hA5,
   parameter int         CNT_W  = 16,
   localparam int        IDX_W  = $clog2(LAYERS),
   localparam int        RD_W   = IDX_W + 1
)(
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             scroll,
   output logic             gen_layer_select,
   input  logic [ROW_W-1:0] gen_layer_map,
   input  logic [ROW_W-1:0] gen_block_type,
   input  logic [RD_W-1:0]  rd_row,
   output logic [ROW_W-1:0] rd_map,
   output logic [ROW_W-1:0] rd_type,
   output logic             ready,
   output logic             scroll_drop,
   output logic [CNT_W-1:0] scroll_cnt
);

   state_t           r_state;
   state_t           w_next;
   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_fill_idx;
   logic [CNT_W-1:0] r_scroll_cnt;
   logic             r_scroll_drop;
   logic [ROW_W-1:0] r_map  [LAYERS];
   logic [ROW_W-1:0] r_type [LAYERS];
   logic [ROW_W-1:0] r_rd_map;
   logic [ROW_W-1:0] r_rd_type;

   logic [7:0]       w_lfsr;
   logic             w_lfsr_unused;
   logic [ROW_W-1:0] w_gen_map;
   logic [ROW_W-1:0] w_gen_type;
   logic             w_we;
   logic [IDX_W-1:0] w_waddr;
   logic [ROW_W-1:0] w_wmap;
   logic [ROW_W-1:0] w_wtype;
   logic             w_drop;
   logic [IDX_W-1:0] w_raddr;

   lfsr8 u_lfsr (
      .pclk  (pclk),
      .rst_n (rst_n),
      .seed  (SEED),
      .out   (w_lfsr)
   );

   assign gen_layer_select = w_lfsr[0];
   assign w_lfsr_unused    = ^w_lfsr[7:1];

   // An empty generated row would leave the player nowhere to land
   assign w_gen_map  = (gen_layer_map == '0) ? ROW_W'(FALLBACK_MAP) : gen_layer_map;
   assign w_gen_type = (gen_layer_map == '0) ? '0 : gen_block_type;

   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = r_head;
      w_wmap  = w_gen_map;
      w_wtype = w_gen_type;
      w_drop  = scroll && !init && (r_state != S_READY);
      if (init) begin
         w_next = S_FILL;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_FILL: begin
               w_we    = 1'b1;
               w_waddr = r_fill_idx;
               if (r_fill_idx == '0) begin
                  w_wmap  = ROW_W'(FLOOR_MAP);
                  w_wtype = '0;
               end
               if (r_fill_idx == IDX_W'(LAYERS - 1)) begin
                  w_next = S_READY;
               end
            end
            S_READY: begin
               if (scroll) begin
                  w_next = S_SCROLL;
               end
            end
            S_SCROLL: begin
               w_we   = 1'b1;
               w_next = S_READY;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   assign w_raddr = r_head + rd_row[IDX_W-1:0];

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_head        <= '0;
         r_fill_idx    <= '0;
         r_scroll_cnt  <= '0;
         r_scroll_drop <= 1'b0;
         r_rd_map      <= '0;
         r_rd_type     <= '0;
         for (int i = 0; i < LAYERS; i++) begin
            r_map[i]  <= '0;
            r_type[i] <= '0;
         end
      end else begin
         r_state       <= w_next;
         r_scroll_drop <= w_drop;
         if (init) begin
            r_head       <= '0;
            r_fill_idx   <= '0;
            r_scroll_cnt <= '0;
         end else if (r_state == S_FILL) begin
            r_fill_idx <= r_fill_idx + 1'b1;
         end else if (r_state == S_SCROLL) begin
            r_head <= r_head + 1'b1;
            if (r_scroll_cnt != '1) begin
               r_scroll_cnt <= r_scroll_cnt + 1'b1;
            end
         end
         if (w_we) begin
            r_map[w_waddr]  <= w_wmap;
            r_type[w_waddr] <= w_wtype;
         end
         // Reads see the pre-write contents of a slot written this cycle
         if (rd_row >= RD_W'(LAYERS)) begin
            r_rd_map  <= '0;
            r_rd_type <= '0;
         end else begin
            r_rd_map  <= r_map[w_raddr];
            r_rd_type <= r_type[w_raddr];
         end
      end
   end

   assign ready       = (r_state == S_READY);
   assign scroll_drop = r_scroll_drop;
   assign scroll_cnt  = r_scroll_cnt;
   assign rd_map      = r_rd_map;
   assign rd_type     = r_rd_type;

endmodule

`default_nettype wire

// File: tb/tb_layer_scheduler.sv
// ============================================================================
// Module : tb_layer_scheduler
// Brief  : Directed self-checking bench for layer_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_layer_scheduler;

   logic        pclk;
   logic        rst_n;
   logic        init;
   logic        scroll;
   logic        gen_layer_select;
   logic [6:0]  gen_layer_map;
   logic [6:0]  gen_block_type;
   logic [3:0]  rd_row;
   logic [6:0]  rd_map;
   logic [6:0]  rd_type;
   logic        ready;
   logic        scroll_drop;
   logic [15:0] scroll_cnt;

   logic        sat_sel_unused;
   logic [6:0]  sat_map_unused;
   logic [6:0]  sat_type_unused;
   logic        sat_ready_unused;
   logic        sat_drop_unused;
   logic [1:0]  sat_cnt;

   logic        zero_map;
   logic [7:0]  m_lfsr;
   logic [6:0]  e_map  [8];
   logic [6:0]  e_type [8];
   int          checks;
   int          errors;

   layer_scheduler #(.LAYERS(8), .ROW_W(7), .SEED(8'hA5), .CNT_W(16)) dut (
      .pclk             (pclk),
      .rst_n            (rst_n),
      .init             (init),
      .scroll           (scroll),
      .gen_layer_select (gen_layer_select),
      .gen_layer_map    (gen_layer_map),
      .gen_block_type   (gen_block_type),
      .rd_row           (rd_row),
      .rd_map           (rd_map),
      .rd_type          (rd_type),
      .ready            (ready),
      .scroll_drop      (scroll_drop),
      .scroll_cnt       (scroll_cnt)
   );

   // Narrow-counter twin driven identically, to reach counter saturation quickly
   layer_scheduler #(.LAYERS(8), .ROW_W(7), .SEED(8'hA5), .CNT_W(2)) dut_sat (
      .pclk             (pclk),
      .rst_n            (rst_n),
      .init             (init),
      .scroll           (scroll),
      .gen_layer_select (sat_sel_unused),
      .gen_layer_map    (gen_layer_map),
      .gen_block_type   (gen_block_type),
      .rd_row           (rd_row),
      .rd_map           (sat_map_unused),
      .rd_type          (sat_type_unused),
      .ready            (sat_ready_unused),
      .scroll_drop      (sat_drop_unused),
      .scroll_cnt       (sat_cnt)
   );

   function automatic logic [6:0] f_map(input logic s);
      return s ? 7'b1010101 : 7'b0110110;
   endfunction

   function automatic logic [6:0] f_type(input logic s);
      return s ? 7'b1000101 : 7'b0010010;
   endfunction

   // Block generator stand-in
   assign gen_layer_map  = zero_map ? 7'd0 : f_map(gen_layer_select);
   assign gen_block_type = f_type(gen_layer_select);

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(posedge pclk) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic push_row(input logic zm);
      for (int i = 0; i < 7; i++) begin
         e_map[i]  = e_map[i+1];
         e_type[i] = e_type[i+1];
      end
      e_map[7]  = zm ? 7'b0001000 : f_map(m_lfsr[0]);
      e_type[7] = zm ? 7'd0 : f_type(m_lfsr[0]);
   endtask

   // Called right after the edge that accepted init
   task automatic do_fill(input logic [7:0] zmask);
      for (int i = 0; i < 8; i++) begin
         zero_map = zmask[i];
         checks++;
         if (ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready_low cycle %0d got %b want 0", i, ready);
         end
         checks++;
         if (gen_layer_select !== m_lfsr[0]) begin
            errors++;
            $display("FAIL gen_select cycle %0d got %b want %b", i, gen_layer_select, m_lfsr[0]);
         end
         if (i == 0) begin
            e_map[0]  = 7'h7F;
            e_type[0] = 7'd0;
         end else begin
            e_map[i]  = zmask[i] ? 7'b0001000 : f_map(m_lfsr[0]);
            e_type[i] = zmask[i] ? 7'd0 : f_type(m_lfsr[0]);
         end
         tick;
      end
      zero_map = 1'b0;
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_ready_high got %b want 1", ready);
      end
   endtask

   task automatic do_scroll;
      scroll = 1'b1;
      tick;
      scroll = 1'b0;
      push_row(1'b0);
      tick;
   endtask

   task automatic check_all_rows(input string tag);
      for (int r = 0; r < 8; r++) begin
         rd_row = 4'(r);
         tick;
         checks++;
         if (rd_map !== e_map[r] || rd_type !== e_type[r]) begin
            errors++;
            $display("FAIL %s row %0d got %b/%b want %b/%b", tag, r, rd_map, rd_type, e_map[r], e_type[r]);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      checks++;
      if (ready !== 1'b0 || scroll_drop !== 1'b0 || scroll_cnt !== 16'd0 || rd_map !== 7'd0 || rd_type !== 7'd0) begin
         errors++;
         $display("FAIL reset_outputs got r%b d%b c%h m%b t%b want all 0", ready, scroll_drop, scroll_cnt, rd_map, rd_type);
      end
      checks++;
      if (gen_layer_select !== 1'b1) begin
         errors++;
         $display("FAIL reset_select got %b want 1", gen_layer_select);
      end
      rst_n  = 1'b1;
      rd_row = 4'd3;
      tick;
      checks++;
      if (rd_map !== 7'd0 || rd_type !== 7'd0) begin
         errors++;
         $display("FAIL reset_buffer got %b/%b want 0/0", rd_map, rd_type);
      end
   endtask

   task automatic test_fill;
      init = 1'b1;
      tick;
      init = 1'b0;
      do_fill(8'h00);
      check_all_rows("fill");
      rd_row = 4'd8;
      tick;
      checks++;
      if (rd_map !== 7'd0 || rd_type !== 7'd0) begin
         errors++;
         $display("FAIL read_oob got %b/%b want 0/0", rd_map, rd_type);
      end
   endtask

   task automatic test_scroll;
      scroll = 1'b1;
      tick;
      scroll = 1'b0;
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL scroll_ready_low got %b want 0", ready);
      end
      push_row(1'b0);
      tick;
      checks++;
      if (ready !== 1'b1 || scroll_cnt !== 16'd1 || scroll_drop !== 1'b0) begin
         errors++;
         $display("FAIL scroll_done got r%b c%0d d%b want r1 c1 d0", ready, scroll_cnt, scroll_drop);
      end
      check_all_rows("scroll");
   endtask

   task automatic test_back_to_back;
      scroll = 1'b1;
      tick;
      push_row(1'b0);
      tick;
      scroll = 1'b0;
      checks++;
      if (scroll_drop !== 1'b1 || scroll_cnt !== 16'd2 || ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop got d%b c%0d r%b want d1 c2 r1", scroll_drop, scroll_cnt, ready);
      end
      tick;
      checks++;
      if (scroll_drop !== 1'b0 || scroll_cnt !== 16'd2) begin
         errors++;
         $display("FAIL b2b_after got d%b c%0d want d0 c2", scroll_drop, scroll_cnt);
      end
      check_all_rows("b2b");
   endtask

   task automatic test_init_scroll;
      init   = 1'b1;
      scroll = 1'b1;
      tick;
      init   = 1'b0;
      scroll = 1'b0;
      checks++;
      if (scroll_drop !== 1'b0 || scroll_cnt !== 16'd0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL init_scroll got d%b c%0d r%b want d0 c0 r0", scroll_drop, scroll_cnt, ready);
      end
      do_fill(8'b0010_0100);
      check_all_rows("fallback");
      rd_row = 4'd8;
      tick;
      checks++;
      if (rd_map !== 7'd0 || rd_type !== 7'd0) begin
         errors++;
         $display("FAIL read_oob2 got %b/%b want 0/0", rd_map, rd_type);
      end
   endtask

   task automatic test_fill_restart;
      do_scroll;
      init = 1'b1;
      tick;
      init = 1'b0;
      tick;
      tick;
      tick;
      init = 1'b1;
      tick;
      init = 1'b0;
      do_fill(8'h00);
      check_all_rows("restart");
   endtask

   task automatic test_saturation;
      logic [1:0] want_sat;
      init = 1'b1;
      tick;
      init = 1'b0;
      do_fill(8'h00);
      for (int k = 1; k <= 4; k++) begin
         do_scroll;
         want_sat = (k > 3) ? 2'd3 : 2'(k);
         checks++;
         if (scroll_cnt !== 16'(k) || sat_cnt !== want_sat) begin
            errors++;
            $display("FAIL sat_count step %0d got %0d/%0d want %0d/%0d", k, scroll_cnt, sat_cnt, k, want_sat);
         end
      end
      check_all_rows("multi_scroll");
   endtask

   task automatic test_reset_mid_fill;
      rd_row = 4'd0;
      init   = 1'b1;
      tick;
      init   = 1'b0;
      tick;
      tick;
      tick;
      rst_n = 1'b0;
      tick;
      checks++;
      if (ready !== 1'b0 || scroll_drop !== 1'b0 || scroll_cnt !== 16'd0 || rd_map !== 7'd0 || rd_type !== 7'd0) begin
         errors++;
         $display("FAIL midfill_reset got r%b d%b c%0d m%b t%b want all 0", ready, scroll_drop, scroll_cnt, rd_map, rd_type);
      end
      rst_n  = 1'b1;
      scroll = 1'b1;
      tick;
      scroll = 1'b0;
      checks++;
      if (scroll_drop !== 1'b1 || scroll_cnt !== 16'd0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_drop got d%b c%0d r%b want d1 c0 r0", scroll_drop, scroll_cnt, ready);
      end
      tick;
      checks++;
      if (rd_map !== 7'd0 || scroll_drop !== 1'b0) begin
         errors++;
         $display("FAIL midfill_cleared got m%b d%b want 0 0", rd_map, scroll_drop);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      init     = 1'b0;
      scroll   = 1'b0;
      rd_row   = 4'd0;
      zero_map = 1'b0;
      for (int i = 0; i < 8; i++) begin
         e_map[i]  = 7'd0;
         e_type[i] = 7'd0;
      end
      test_reset;
      test_fill;
      test_scroll;
      test_back_to_back;
      test_init_scroll;
      test_fill_restart;
      test_saturation;
      test_reset_mid_fill;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Owns the vertical stack of platform layers shown on screen.
- Drives the combinational block generator (layer_select out; layer_map and block_type in) and buffers LAYERS generated rows in a ring buffer.
- On game init it fills the stack. On each scroll it drops the bottom row and appends a freshly generated top row.
- Exposes a registered random-access read port for the drawing logic and a scroll counter for scoring.

Parameters:
- LAYERS, 8, rows held in the buffer (power of two, 2..16).
- ROW_W, 7, blocks per layer; must match the generator output width.
- SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01.
- CNT_W, 16, width of scroll_cnt.

Ports:
- pclk  in  1  system pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- init  in  1  one-cycle pulse: start a new game (refill the stack).
- scroll  in  1  one-cycle pulse: advance the stack by one layer.
- gen_layer_select  out  1  select line to the block generator.
- gen_layer_map  in  ROW_W  generator block presence map, bit 0 = leftmost.
- gen_block_type  in  ROW_W  generator block type map.
- rd_row  in  log2(LAYERS)+1  logical row to read; 0 = bottom (oldest).
- rd_map  out  ROW_W  registered map of rd_row.
- rd_type  out  ROW_W  registered type of rd_row.
- ready  out  1  stack valid and accepting scroll.
- scroll_drop  out  1  one-cycle pulse: scroll arrived while not ready.
- scroll_cnt  out  CNT_W  accepted scrolls since last init; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, all buffer entries 0, head=0, fill_idx=0.
  - lfsr=SEED, ready=0, scroll_drop=0, scroll_cnt=0, rd_map=0, rd_type=0.
  - Reset mid-FILL or mid-SCROLL aborts the operation immediately.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. It advances every cycle when not in reset. gen_layer_select = lfsr[0].
- Generator sampling: the generator is combinational, so its outputs are sampled in the same cycle gen_layer_select is driven.
- Empty-layer substitution: if a sampled gen_layer_map == 0, write map 7'b0001000 with type 0 instead.
- IDLE:
  - ready=0.
  - init -> FILL with fill_idx=0, head=0, scroll_cnt=0.
  - scroll -> scroll_drop pulse.
- FILL (one row per cycle):
  - Row 0 is forced to map all-ones, type 0, as the starting floor.
  - Rows 1..LAYERS-1 take the sampled generator output.
  - After writing row LAYERS-1 -> READY. Total LAYERS cycles from init to ready=1 (ready rises in cycle LAYERS+1).
- READY:
  - ready=1.
  - scroll -> SCROLL.
  - init -> FILL, which clears scroll_cnt and head.
- SCROLL (exactly one cycle, ready=0):
  - Overwrite the physical slot at head (the old bottom row) with the sampled generator row.
  - head = (head+1) mod LAYERS.
  - scroll_cnt += 1, saturating at all-ones.
  - Next state READY.
  - Throughput: at most one scroll per 2 cycles.
- Scroll arriving while ready=0 (IDLE, FILL, SCROLL): ignored, scroll_drop=1 for one cycle, scroll_cnt unchanged.
- Simultaneous init and scroll: init wins, no scroll_drop.
- init during FILL restarts the fill from row 0.
- Read port:
  - Physical index = (head + rd_row) mod LAYERS.
  - rd_map and rd_type are registered, 1-cycle latency, and valid in every state (buffer contents as currently stored).
  - rd_row >= LAYERS returns 0 on both outputs.
  - A read of a slot being written in the same cycle returns the old value.
- All arithmetic is unsigned. head and fill_idx wrap modulo LAYERS.

Decomposition:
- Shared package or header `skyhop_defs`:
  - ROW_W.
  - State encoding localparams (S_IDLE=0, S_FILL=1, S_READY=2, S_SCROLL=3).
  - FLOOR_MAP = all-ones.
  - FALLBACK_MAP = 7'b0001000.
  - LFSR tap mask.
- One sub-module is natural: `lfsr8` (pclk, rst_n, seed, out[7:0]), reusable elsewhere in the game.
- The block generator is instantiated outside and wired at top level.

Test Plan:
- Reset, then init pulse -> ready=0 for 8 cycles, ready=1 on cycle 9 after init. Row 0 reads map 7'h7F, type 0. Rows 1..7 match generator outputs for the logged lfsr[0] sequence, e.g. select=1 gives 7'b1010101/7'b1000101.
- READY, scroll pulse -> ready low 1 cycle. Reading rd_row 0 returns the former row 1, rd_row 7 returns the new row, scroll_cnt=1.
- Two scroll pulses on consecutive cycles -> first accepted, second gives scroll_drop=1, scroll_cnt incremented once.
- init and scroll asserted in the same cycle while READY -> refill starts, scroll_cnt=0, no scroll_drop.
- Force gen_layer_map=0 during FILL -> affected rows read 7'b0001000, type 0. rd_row=8 reads 0/0.
- rst_n low on the 4th FILL cycle -> next cycle all outputs 0, state IDLE. A scroll then pulses scroll_drop. Preload scroll_cnt to 16'hFFFF via force, then scroll -> stays 16'hFFFF.
